// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with a one-entry skid buffer for decode stalls,
// flush squashing, and saturating stall/flush/bubble performance counters.
module if_id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pc_i,
   input  logic [31:0]      pc_4_i,
   input  logic [31:0]      instr_i,
   input  logic             instr_valid_i,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic             fetch_stall_o,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_pc_4,
   output logic [31:0]      id_instr,
   output logic             id_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic        hold_valid;
   logic [31:0] hold_pc;
   logic [31:0] hold_pc_4;
   logic [31:0] hold_instr;
   logic        stall_hit;
   logic        bubble_hit;

   // Holding the PC is a pure function of skid occupancy, so this stays a registered path.
   assign fetch_stall_o = hold_valid;
   assign stall_hit     = stall_i && !flush_i;
   assign bubble_hit    = !stall_i && !flush_i && !hold_valid && !instr_valid_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid   <= 1'b0;
         id_instr   <= NOP_INSTR;
         id_pc      <= '0;
         id_pc_4    <= '0;
         hold_valid <= 1'b0;
         hold_pc    <= '0;
         hold_pc_4  <= '0;
         hold_instr <= '0;
      end else if (flush_i) begin
         id_valid   <= 1'b0;
         id_instr   <= NOP_INSTR;
         hold_valid <= 1'b0;
      end else if (stall_i) begin
         if (!hold_valid && instr_valid_i) begin
            hold_pc    <= pc_i;
            hold_pc_4  <= pc_4_i;
            hold_instr <= instr_i;
            hold_valid <= 1'b1;
         end
      end else if (hold_valid) begin
         id_pc      <= hold_pc;
         id_pc_4    <= hold_pc_4;
         id_instr   <= hold_instr;
         id_valid   <= 1'b1;
         hold_valid <= 1'b0;
      end else begin
         id_pc    <= pc_i;
         id_pc_4  <= pc_4_i;
         id_instr <= instr_valid_i ? instr_i : NOP_INSTR;
         id_valid <= instr_valid_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         stall_cnt  <= (stall_hit && stall_cnt != CNT_MAX) ? stall_cnt + CNT_ONE : stall_cnt;
         flush_cnt  <= (flush_i && flush_cnt != CNT_MAX) ? flush_cnt + CNT_ONE : flush_cnt;
         bubble_cnt <= (bubble_hit && bubble_cnt != CNT_MAX) ? bubble_cnt + CNT_ONE : bubble_cnt;
      end
   end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed vector table plus hand sequences for reset and counter saturation.
module tb_if_id_stage;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [31:0]      pc_i = '0;
   logic [31:0]      pc_4_i = 32'd4;
   logic [31:0]      instr_i = '0;
   logic             instr_valid_i = 1'b0;
   logic             stall_i = 1'b0;
   logic             flush_i = 1'b0;
   logic             fetch_stall_o;
   logic [31:0]      id_pc, id_pc_4, id_instr;
   logic             id_valid;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, bubble_cnt;

   int checks = 0;
   int errors = 0;

   if_id_stage #(.NOP_INSTR(32'h0000_0000), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_4_i(pc_4_i), .instr_i(instr_i),
      .instr_valid_i(instr_valid_i), .stall_i(stall_i), .flush_i(flush_i),
      .fetch_stall_o(fetch_stall_o), .id_pc(id_pc), .id_pc_4(id_pc_4), .id_instr(id_instr),
      .id_valid(id_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ev;
      logic [31:0] einstr;
      logic [31:0] epc;
      logic        efs;
   } vec_t;

   vec_t v[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic f, input logic iv, input logic [31:0] pc,
                        input logic [31:0] ins);
      stall_i       = s;
      flush_i       = f;
      instr_valid_i = iv;
      pc_i          = pc;
      pc_4_i        = pc + 32'd4;
      instr_i       = ins;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      v[0]  = '{1'b0, 1'b0, 1'b1, 32'h3000, 32'hAAAA_0001, 1'b1, 32'hAAAA_0001, 32'h3000, 1'b0};
      v[1]  = '{1'b0, 1'b0, 1'b1, 32'h3004, 32'hBBBB_0002, 1'b1, 32'hBBBB_0002, 32'h3004, 1'b0};
      v[2]  = '{1'b0, 1'b0, 1'b1, 32'h3008, 32'hCCCC_0003, 1'b1, 32'hCCCC_0003, 32'h3008, 1'b0};
      v[3]  = '{1'b0, 1'b0, 1'b1, 32'h300C, 32'hDDDD_0004, 1'b1, 32'hDDDD_0004, 32'h300C, 1'b0};
      v[4]  = '{1'b1, 1'b0, 1'b1, 32'h3010, 32'hEEEE_0005, 1'b1, 32'hDDDD_0004, 32'h300C, 1'b1};
      v[5]  = '{1'b1, 1'b0, 1'b1, 32'h3014, 32'hFFFF_0006, 1'b1, 32'hDDDD_0004, 32'h300C, 1'b1};
      v[6]  = '{1'b1, 1'b0, 1'b1, 32'h3014, 32'hFFFF_0006, 1'b1, 32'hDDDD_0004, 32'h300C, 1'b1};
      v[7]  = '{1'b0, 1'b0, 1'b1, 32'h3014, 32'hFFFF_0006, 1'b1, 32'hEEEE_0005, 32'h3010, 1'b0};
      v[8]  = '{1'b0, 1'b0, 1'b1, 32'h3014, 32'hFFFF_0006, 1'b1, 32'hFFFF_0006, 32'h3014, 1'b0};
      v[9]  = '{1'b1, 1'b0, 1'b1, 32'h3018, 32'h1111_0007, 1'b1, 32'hFFFF_0006, 32'h3014, 1'b1};
      v[10] = '{1'b1, 1'b1, 1'b1, 32'h301C, 32'h2222_0008, 1'b0, 32'h0000_0000, 32'h3014, 1'b0};
      v[11] = '{1'b0, 1'b0, 1'b0, 32'h4000, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'h4000, 1'b0};
      v[12] = '{1'b0, 1'b0, 1'b0, 32'h4000, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'h4000, 1'b0};
      v[13] = '{1'b0, 1'b0, 1'b1, 32'h4000, 32'h3333_0009, 1'b1, 32'h3333_0009, 32'h4000, 1'b0};
      v[14] = '{1'b1, 1'b0, 1'b0, 32'h4004, 32'hDEAD_BEEF, 1'b1, 32'h3333_0009, 32'h4000, 1'b0};
      v[15] = '{1'b0, 1'b0, 1'b1, 32'h4004, 32'h4444_000A, 1'b1, 32'h4444_000A, 32'h4004, 1'b0};

      // Power-on reset state
      #2;
      chk("reset id_valid", 32'(id_valid), 32'd0);
      chk("reset id_instr", id_instr, 32'h0);
      chk("reset id_pc", id_pc, 32'h0);
      chk("reset fetch_stall", 32'(fetch_stall_o), 32'd0);
      step();
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         drive(v[i].stall, v[i].flush, v[i].iv, v[i].pc, v[i].instr);
         step();
         chk($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(v[i].ev));
         chk($sformatf("v%0d id_instr", i), id_instr, v[i].einstr);
         chk($sformatf("v%0d id_pc", i), id_pc, v[i].epc);
         chk($sformatf("v%0d id_pc_4", i), id_pc_4, v[i].epc + 32'd4);
         chk($sformatf("v%0d fetch_stall", i), 32'(fetch_stall_o), 32'(v[i].efs));
         if (i == 8) chk("stall_cnt after skid", 32'(stall_cnt), 32'd3);
         if (i == 10) begin
            chk("flush_cnt after flush", 32'(flush_cnt), 32'd1);
            chk("stall_cnt after flush", 32'(stall_cnt), 32'd4);
         end
         if (i == 12) chk("bubble_cnt", 32'(bubble_cnt), 32'd2);
      end
      chk("final stall_cnt", 32'(stall_cnt), 32'd5);
      chk("final flush_cnt", 32'(flush_cnt), 32'd1);
      chk("final bubble_cnt", 32'(bubble_cnt), 32'd2);

      // Asynchronous reset mid-stall with the skid buffer occupied
      drive(1'b1, 1'b0, 1'b1, 32'h5000, 32'h5555_000B);
      step();
      chk("pre-reset fetch_stall", 32'(fetch_stall_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async id_valid", 32'(id_valid), 32'd0);
      chk("async id_instr", id_instr, 32'h0);
      chk("async id_pc_4", id_pc_4, 32'h0);
      chk("async fetch_stall", 32'(fetch_stall_o), 32'd0);
      chk("async stall_cnt", 32'(stall_cnt), 32'd0);
      chk("async flush_cnt", 32'(flush_cnt), 32'd0);
      chk("async bubble_cnt", 32'(bubble_cnt), 32'd0);
      step();
      rst_n = 1'b1;

      // Skid stays empty after reset: a clean advance loads directly from inputs
      drive(1'b0, 1'b0, 1'b1, 32'h6000, 32'h6666_000C);
      step();
      chk("post-reset id_instr", id_instr, 32'h6666_000C);
      chk("post-reset id_pc_4", id_pc_4, 32'h6004);

      // Saturation: 20 stall cycles on a 4-bit counter
      drive(1'b1, 1'b0, 1'b0, 32'h6004, 32'h0);
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 14) chk("stall_cnt at 14", 32'(stall_cnt), 32'd14);
         if (c == 15) chk("stall_cnt at 15", 32'(stall_cnt), 32'd15);
      end
      chk("stall_cnt saturated", 32'(stall_cnt), 32'd15);
      chk("bubble_cnt during stall", 32'(bubble_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline stage of the 5-stage MIPS core. Sits directly downstream of the PC register and instruction memory.
- Captures the fetched instruction with its pc and pc_4 and presents them to the decode stage.
- Absorbs decode stalls with a one-entry skid buffer and squashes wrong-path instructions on flush.
- Raises fetch_stall so the next-PC mux re-selects the current pc while the skid buffer is occupied.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word driven on id_instr when the stage is empty (sll $0,$0,0).
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- pc_i  input  32  pc of the instruction on instr_i (PC register output)
- pc_4_i  input  32  pc_i + 4 (PC register output)
- instr_i  input  32  instruction memory read data, combinational from pc_i
- instr_valid_i  input  1  instr_i is valid this cycle; 0 = imem not ready
- stall_i  input  1  decode hazard stall: hold the ID outputs
- flush_i  input  1  branch/jump redirect: squash the stage
- fetch_stall_o  output  1  next-PC mux must select pc (hold PC)
- id_pc  output  32  pc of the ID instruction
- id_pc_4  output  32  pc_4 of the ID instruction
- id_instr  output  32  ID instruction word
- id_valid  output  1  ID instruction is real, not a bubble
- stall_cnt  output  CNT_W  cycles with stall_i=1 and flush_i=0, saturating
- flush_cnt  output  CNT_W  cycles with flush_i=1, saturating
- bubble_cnt  output  CNT_W  advance cycles that loaded a bubble, saturating

Behaviour:
- Reset is asynchronous on rst_n low and applies immediately, including mid-stall:
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_4=0.
  - Skid buffer empty (hold_valid=0); fetch_stall_o=0.
  - All counters 0.
- Storage: ID register set {pc, pc_4, instr, valid} and skid register set {pc, pc_4, instr} plus hold_valid.
- fetch_stall_o = hold_valid exactly. It is a registered path: no combinational path from stall_i, flush_i or instr_valid_i.
- Latency: an instruction accepted at edge n appears on id_* after edge n. This is one cycle of latency.
- The three cases below are evaluated at each rising edge and are mutually exclusive, in priority order.
- Case 1, flush_i=1 (overrides stall_i):
  - id_valid<=0, id_instr<=NOP_INSTR; id_pc and id_pc_4 keep their values.
  - hold_valid<=0.
  - The input instruction is discarded.
  - flush_cnt increments.
- Case 2, stall_i=1 and flush_i=0:
  - The ID register set holds.
  - If hold_valid=0 and instr_valid_i=1, the input is captured into the skid buffer and hold_valid<=1. The PC advances this cycle because fetch_stall_o was 0.
  - If hold_valid=1, the input is ignored. The PC is being held, so the same instruction is re-presented later.
  - stall_cnt increments.
- Case 3, advance (stall_i=0, flush_i=0):
  - If hold_valid=1: the ID set is loaded from the skid buffer with valid=1, and hold_valid<=0. The input is ignored; the PC was held, so it re-presents that input next cycle.
  - If hold_valid=0: the ID set is loaded from the inputs with id_valid<=instr_valid_i.
  - When instr_valid_i=0, id_instr<=NOP_INSTR and bubble_cnt increments.
- Ordering: no instruction is lost or duplicated across any stall/flush sequence. A stall followed by release yields back-to-back valid instructions with no bubble.
- Counters: increment by 1 per qualifying cycle and saturate at 2^CNT_W-1; they never wrap.

Test Plan:
- Reset: assert rst_n=0 mid-stream with hold_valid=1 -> id_valid=0, id_instr=0, fetch_stall_o=0 immediately, without waiting for a clock edge; all counters 0.
- Stream: pc 0x3000, 0x3004, 0x3008 with instr A, B, C, all valid, no stall -> id_instr shows A, B, C on consecutive cycles, one cycle late; id_pc_4 shows 0x3004, 0x3008, 0x300C.
- Stall skid:
  - Stimulus: stall_i=1 for 3 cycles while A at 0x3000 is in ID and B at 0x3004 arrives.
  - B is captured; fetch_stall_o=1 from the next cycle; the PC holds 0x3008.
  - On release: id shows B, then C at 0x3008, with no bubble.
  - stall_cnt=3.
- Flush over stall: flush_i=1 and stall_i=1 with hold_valid=1 -> next cycle id_valid=0, hold_valid=0, fetch_stall_o=0; flush_cnt=1; stall_cnt unchanged.
- Imem not ready: instr_valid_i=0 for 2 advance cycles -> id_valid=0 with id_instr=NOP_INSTR for 2 cycles; bubble_cnt=2.
- Saturation: with CNT_W=4, hold stall_i=1 for 20 cycles -> stall_cnt stops at 15 and does not wrap.
